// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, constants and helpers for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_XFER
  } arb_state_t;

  localparam int UART_DW = 8;

  // Successor with an explicit wrap so non-power-of-two requester counts stay in range.
  function automatic logic [7:0] rr_next(input logic [7:0] ptr, input int unsigned n);
    if ({24'd0, ptr} >= n - 1) begin
      return 8'd0;
    end
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// rtl/rr_prio_enc.sv - combinational round-robin priority encoder
// Picks the first set request at or above ptr, wrapping past N_REQ-1 to 0.
module rr_prio_enc
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    gnt_id,
  output logic             any
);

  localparam logic [IW:0] NQ = (IW + 1)'(N_REQ);

  logic [IW:0] sum;

  // Scan from the farthest offset down so the nearest request overwrites the rest.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    sum    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= NQ) begin
        sum = sum - NQ;
      end
      if (req[sum[IW-1:0]]) begin
        gnt_id = sum[IW-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin, message-locked arbiter for the UART transmit byte channel
// Holds the FSM, idle-timeout counter and the one-deep output register feeding the serializer.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DW       = UART_DW,
  parameter int TOUT_CYC = 50000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DW-1:0]        req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_valid,
  output logic [DW-1:0]              tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       tout_evt
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TOUT_CYC + 1);
  localparam logic [CW-1:0] TOUT_MAX = CW'(TOUT_CYC);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic          tx_valid_q, tx_valid_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tout_evt_q, tout_evt_d;

  logic [DW-1:0] data_arr [N_REQ];
  logic [IW-1:0] enc_gnt;
  logic          enc_any;
  logic          out_ok;
  logic [CW-1:0] cnt_inc;
  logic [IW-1:0] ptr_after;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  rr_prio_enc #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_enc (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt_id (enc_gnt),
    .any    (enc_any)
  );

  assign out_ok    = !tx_valid_q || tx_ready;
  assign cnt_inc   = (cnt_q == TOUT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign ptr_after = IW'(rr_next(8'(grant_id_q), N_REQ));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    tout_evt_d = 1'b0;
    req_ready  = '0;

    if (tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (enc_any) begin
          grant_id_d = enc_gnt;
          state_d    = ARB_XFER;
        end
      end
      ARB_XFER: begin
        req_ready[grant_id_q] = out_ok;
        if (out_ok && req_valid[grant_id_q]) begin
          // An accepted byte always beats a timeout landing in the same cycle.
          tx_valid_d = 1'b1;
          tx_data_d  = data_arr[grant_id_q];
          cnt_d      = '0;
          if (req_last[grant_id_q]) begin
            rr_ptr_d = ptr_after;
            state_d  = ARB_IDLE;
          end
        end else if (out_ok) begin
          if (cnt_inc == TOUT_MAX) begin
            tout_evt_d = 1'b1;
            rr_ptr_d   = ptr_after;
            cnt_d      = '0;
            state_d    = ARB_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      tout_evt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      tout_evt_q <= tout_evt_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == ARB_XFER);
  assign tout_evt = tout_evt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard bench for the UART transmit arbiter
module tb_uart_tx_arb;

  logic        sys_clk;
  logic        sys_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tout_evt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tout_cnt = 0;
  int pop_cnt  = 0;
  int pop_cyc[$];
  logic [7:0] exp_q[$];
  int c0;
  int t0;

  uart_tx_arb #(
    .N_REQ    (4),
    .DW       (8),
    .TOUT_CYC (16)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .tout_evt  (tout_evt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (tout_evt) tout_cnt++;
    if (!sys_rst && tx_valid && tx_ready) begin
      check("sb_has", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("sb_byte", tx_data, exp_q.pop_front());
      pop_cyc.push_back(cyc);
      pop_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_msg(input int id, input logic [7:0] b0, input int len, input bit with_last);
    bit acc;
    int n;
    for (int k = 0; k < len; k++) begin
      req_valid[id]        = 1'b1;
      req_data[id*8 +: 8]  = 8'(b0 + k);
      req_last[id]         = with_last && (k == len - 1);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
        @(negedge sys_clk);
        acc = req_ready[id];
        @(posedge sys_clk);
        #1;
        n++;
      end
      check("acc_bound", 32'(acc), 1);
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    idle(2);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_tout", tout_evt, 0);
    check("rst_ready", req_ready, 0);
    check("rst_grant", grant_id, 0);
    sys_rst = 1'b0;

    // single requester, 3-byte message
    pop_cyc.delete();
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    c0 = cyc;
    send_msg(1, 8'h41, 3, 1);
    idle(3);
    check("t1_npop", pop_cyc.size(), 3);
    check("t1_lat", pop_cyc[0] - c0, 2);
    check("t1_span", pop_cyc[2] - pop_cyc[0], 2);
    check("t1_grant", grant_id, 1);
    check("t1_busy", busy, 0);
    check("t1_rr", dut.rr_ptr_q, 2);

    // contention between requesters 0 and 2 from rr_ptr 0
    sys_rst = 1'b1; idle(1); sys_rst = 1'b0;
    pop_cyc.delete();
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
    fork
      send_msg(0, 8'hA0, 2, 1);
      send_msg(2, 8'hB0, 2, 1);
    join
    idle(3);
    check("ct_npop", pop_cyc.size(), 4);
    check("ct_gap0", pop_cyc[1] - pop_cyc[0], 1);
    check("ct_gap1", pop_cyc[2] - pop_cyc[1], 2);
    check("ct_gap2", pop_cyc[3] - pop_cyc[2], 1);
    check("ct_rr", dut.rr_ptr_q, 3);
    check("ct_grant", grant_id, 2);

    // backpressure mid-message
    pop_cnt = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h50 + k));
    fork
      send_msg(1, 8'h50, 4, 1);
      begin
        int n;
        n = 0;
        while (pop_cnt < 2 && n < 100) begin
          @(negedge sys_clk); #1; n++;
        end
        check("bp_start", 32'(pop_cnt >= 2), 1);
        @(posedge sys_clk); #1;
        tx_ready = 1'b0;
        repeat (5) begin
          @(negedge sys_clk);
          check("bp_valid", tx_valid, 1);
          check("bp_hold", tx_data, exp_q[0]);
          check("bp_ready", req_ready[1], 0);
          @(posedge sys_clk); #1;
        end
        tx_ready = 1'b1;
      end
    join
    idle(3);
    check("bp_drain", exp_q.size(), 0);
    check("bp_npop", pop_cnt, 4);

    // timeout of owner 3 while requester 0 waits
    exp_q.push_back(8'hC0); exp_q.push_back(8'hD0);
    send_msg(3, 8'hC0, 1, 0);
    t0 = tout_cnt;
    fork
      send_msg(0, 8'hD0, 1, 1);
      begin
        for (int k = 1; k <= 20; k++) begin
          @(posedge sys_clk); #1;
          if (k == 15) check("to_early", tout_evt, 0);
          if (k == 15) check("to_busy15", busy, 1);
          if (k == 16) check("to_pulse", tout_evt, 1);
          if (k == 16) check("to_idle", busy, 0);
          if (k == 17) check("to_regrant", grant_id, 0);
          if (k == 17) check("to_one", tout_evt, 0);
        end
      end
    join
    idle(3);
    check("to_count", tout_cnt - t0, 1);

    // last byte accepted in the counter's terminal cycle
    exp_q.push_back(8'hE0); exp_q.push_back(8'hE1);
    t0 = tout_cnt;
    send_msg(1, 8'hE0, 1, 0);
    idle(15);
    req_valid[1] = 1'b1; req_data[15:8] = 8'hE1; req_last[1] = 1'b1;
    @(negedge sys_clk);
    check("co_ready", req_ready[1], 1);
    @(posedge sys_clk); #1;
    req_valid[1] = 1'b0; req_last[1] = 1'b0;
    check("co_busy", busy, 0);
    check("co_txd", tx_data, 8'hE1);
    idle(20);
    check("co_tout", tout_cnt - t0, 0);
    check("co_drain", exp_q.size(), 0);

    // reset with a byte pending in the output stage
    tx_ready = 1'b0;
    req_valid[2] = 1'b1; req_data[23:16] = 8'hF0; req_last[2] = 1'b0;
    idle(2);
    check("rm_pend", tx_valid, 1);
    sys_rst = 1'b1;
    idle(1);
    check("rm_tx_valid", tx_valid, 0);
    check("rm_busy", busy, 0);
    check("rm_ready", req_ready, 0);
    check("rm_grant", grant_id, 0);
    sys_rst = 1'b0; tx_ready = 1'b1;
    exp_q.push_back(8'h10); exp_q.push_back(8'hF0);
    fork
      send_msg(0, 8'h10, 1, 1);
      send_msg(2, 8'hF0, 1, 1);
      begin
        idle(1);
        check("rm_regrant", grant_id, 0);
        check("rm_rebusy", busy, 1);
      end
    join
    idle(5);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter sharing the single UART transmit byte channel of `mblite_top` between N byte-stream requesters, e.g. CPU console, debug monitor and status reporter. A requester holds the channel for a whole message, up to and including the byte flagged `req_last`, so messages are never interleaved on `rs232_uart_txd`. The block sits between the requesters and the UART serializer in the `s_clk_50` domain, and drives the serializer through a one-deep registered valid/ready stage.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `DW`, default 8: byte width.
- `TOUT_CYC`, default 50000: consecutive idle cycles of the granted requester before its lock is revoked (1 ms at 50 MHz).
- `sys_clk` in 1: single clock; all logic on its rising edge.
- `sys_rst` in 1: reset, synchronous and active-high.
- `req_valid` in N_REQ: per-requester byte valid.
- `req_data` in N_REQ*DW: requester i occupies bits [i*DW +: DW].
- `req_last` in N_REQ: the byte is the final byte of its message.
- `req_ready` out N_REQ: byte accepted when `req_valid[i] & req_ready[i]`.
- `tx_valid` out 1: byte for the serializer.
- `tx_data` out DW: the byte for the serializer.
- `tx_ready` in 1: serializer accepts the byte.
- `grant_id` out $clog2(N_REQ): current or last owner.
- `busy` out 1: high in XFER state.
- `tout_evt` out 1: one-cycle pulse when a lock is revoked.

## Operation
- **IDLE:** if any `req_valid` is set, select the first set bit scanning from `rr_ptr` upward, with wrap. Load `grant_id` and go to XFER next cycle. If none is set, stay in IDLE.
- **XFER:**
  - `req_ready[grant_id] = (!tx_valid | tx_ready)`. All other `req_ready` bits are 0. `req_ready` is 0 for every requester in IDLE.
  - On an accepted byte, load `tx_data` with the byte and set `tx_valid`.
  - If the accepted byte has `req_last`, set `rr_ptr = grant_id+1` (mod N_REQ) and go to IDLE.
- **Output stage:** `tx_valid` clears on `tx_ready` unless a new byte is loaded in the same cycle. `tx_data` holds stable while `tx_valid & !tx_ready`.
- **Timeout:**
  - The counter increments in XFER only when the owner has `!req_valid[grant_id]` and the output stage can accept (`!tx_valid | tx_ready`). Any accepted byte clears it, and so does leaving XFER.
  - Counter stalls caused by the serializer do not count toward the timeout.
  - When the counter reaches `TOUT_CYC`: pulse `tout_evt`, advance `rr_ptr = grant_id+1`, go to IDLE. The message is truncated and no byte is fabricated.
- **Counter width:** $clog2(TOUT_CYC+1). It saturates and never wraps.
- **Simultaneous `req_last` accept and timeout:** the accept wins; there is no `tout_evt`.
- **`rr_ptr` arithmetic:** modulo N_REQ. When N_REQ is not a power of two, a value of N_REQ-1 wraps to 0 explicitly.
- **Reset values:** state=IDLE, `rr_ptr`=0, `grant_id`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `tout_evt`=0, `req_ready`=0, counter=0.
- **Reset mid-message:** a byte pending in the output stage is dropped, and the lock is lost.

## Timing
- Arbitration takes 1 cycle. The first `req_ready` assertion comes in the cycle after IDLE sees `req_valid`.
- Data latency is 1 cycle: a byte accepted at edge k is on `tx_data`/`tx_valid` after edge k.
- Sustained throughput is 1 byte/cycle when `tx_ready` is held high.
- Inter-message gap is at least 1 IDLE cycle, in which `tx_valid` may still hold the last byte.
- `req_ready` is combinational from state and `tx_valid`/`tx_ready`; it must not depend on `req_valid`.
- `tout_evt` is asserted in the same cycle the state register moves to IDLE.

## Structure
- **Package `uart_arb_pkg`:**
  - state enum `arb_state_t {ARB_IDLE, ARB_XFER}`;
  - constant `UART_DW = 8`;
  - function `rr_next(ptr, n)`.
- **Sub-module `rr_prio_enc`:** inputs `req` and `ptr`, outputs `gnt_id` and `any`; purely combinational rotate-and-scan. The top level holds the FSM, counter and output register.

## Test plan
- **Single requester, 3-byte message:** with `tx_ready`=1, requester 1 sends 0x41, 0x42, 0x43(last). `tx_data` shows 0x41, 0x42, 0x43 on consecutive cycles, starting 2 cycles after `req_valid` rises. `grant_id`=1, then IDLE. `rr_ptr`=2.
- **Contention:** requesters 0 and 2 each hold a 2-byte message, `rr_ptr`=0. Output is req0 bytes, a 1-cycle gap, then req2 bytes. The bytes never interleave. `rr_ptr`=3 at the end.
- **Backpressure:** `tx_ready` is held low for 5 cycles mid-message. `tx_data` stays stable and `req_ready[g]`=0 throughout. No byte is lost or duplicated once `tx_ready` returns.
- **Timeout (TOUT_CYC=16 in the bench):** owner 3 sends 1 byte without last, then idles. After 16 idle cycles `tout_evt` pulses once and the FSM goes to IDLE. Waiting requester 0 is granted next.
- **Last and timeout coincide:** the `req_last` byte is accepted in the counter's terminal cycle. There is no `tout_evt` and the byte is transmitted.
- **Reset mid-message:** `sys_rst` is asserted for 1 cycle with `tx_valid`=1. The next cycle shows `tx_valid`=0, `busy`=0, `req_ready`=0 and `grant_id`=0. Arbitration restarts from requester 0.
